pmem_responder: RTL and testbench

Physical-memory responder on the far side of the cache arbiter's pmem port. Accepts one line-wide read or write at a time, waits a programmable latency, and returns a single-cycle `pmem_resp` with read data. It is the target the arbiter and both caches are exercised against in simulation, and it stands in for the DRAM controller on the board build.

---
 rtl/pmem_types_pkg.sv | 21 ++
 rtl/pmem_line_array.sv | 34 +++
 rtl/pmem_responder.sv | 186 ++++++++++++++++++
 tb/tb_pmem_responder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_types_pkg.sv
// Shared types and default geometry for the physical-memory responder.
// Contents:
//   LINE_BYTES, ADDR_WIDTH, LINE_OFFSET_BITS - default geometry constants
//   pmem_line_t                              - one memory line (8*LINE_BYTES bits)
//   pmem_state_e                             - responder FSM state encoding
package pmem_types_pkg;

    localparam int unsigned LINE_BYTES       = 32;
    localparam int unsigned ADDR_WIDTH       = 32;
    localparam int unsigned LINE_OFFSET_BITS = $clog2(LINE_BYTES);

    typedef logic [8*LINE_BYTES-1:0] pmem_line_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESP    = 2'd2,
        RECOVER = 2'd3
    } pmem_state_e;

endpackage

// File: rtl/pmem_line_array.sv
// Line storage for the responder: DEPTH_LINES lines of LINE_W bits each.
// The array is deliberately not reset; contents are undefined until written.
// Ports:
//   clk   - write clock, rising edge
//   we    - write enable, commits wdata to waddr at the clock edge
//   waddr - line index for writes
//   wdata - line to write
//   raddr - line index for the combinational read port
//   rdata - line at raddr (combinational)
module pmem_line_array #(
    parameter int unsigned DEPTH_LINES = 256,
    parameter int unsigned LINE_W      = 256
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [$clog2(DEPTH_LINES)-1:0] waddr,
    input  logic [LINE_W-1:0]              wdata,
    input  logic [$clog2(DEPTH_LINES)-1:0] raddr,
    output logic [LINE_W-1:0]              rdata
);

    logic [LINE_W-1:0] mem [DEPTH_LINES];

    // Synchronous write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Combinational read port
    assign rdata = mem[raddr];

endmodule

// File: rtl/pmem_responder.sv
// Physical-memory responder: accepts one line read or write at a time,
// waits a per-op programmable latency, then pulses pmem_resp for one cycle.
// A RECOVER cycle after each response swallows a request that is still held
// high, so a slow requester is never served twice.
// Optional feature: define PMEM_RESPONDER_STATS_EN to build saturating
// completed-read/write counters; otherwise read_count/write_count are 0.
// Ports:
//   clk, reset        - clock (rising edge), asynchronous active-high reset
//   pmem_read/write   - request strobes, held by requester until pmem_resp
//   pmem_address      - byte address of the line
//   pmem_wdata        - write line
//   pmem_resp         - one-cycle completion pulse (decode of RESP state)
//   pmem_rdata        - registered read line, held until the next read
//   protocol_err      - sticky: read and write seen together at acceptance
//   read_count        - completed reads (stats build only)
//   write_count       - completed writes (stats build only)
module pmem_responder #(
    parameter int unsigned ADDR_WIDTH    = pmem_types_pkg::ADDR_WIDTH,
    parameter int unsigned LINE_BYTES    = pmem_types_pkg::LINE_BYTES,
    parameter int unsigned DEPTH_LINES   = 256,
    parameter int unsigned READ_LATENCY  = 10,
    parameter int unsigned WRITE_LATENCY = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pmem_read,
    input  logic                    pmem_write,
    input  logic [ADDR_WIDTH-1:0]   pmem_address,
    input  logic [8*LINE_BYTES-1:0] pmem_wdata,
    output logic                    pmem_resp,
    output logic [8*LINE_BYTES-1:0] pmem_rdata,
    output logic                    protocol_err,
    output logic [31:0]             read_count,
    output logic [31:0]             write_count
);

    import pmem_types_pkg::*;

    localparam int unsigned LINE_W  = 8 * LINE_BYTES;
    localparam int unsigned OFF_W   = $clog2(LINE_BYTES);
    localparam int unsigned IDX_W   = $clog2(DEPTH_LINES);
    localparam int unsigned MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT) + 1;

    pmem_state_e       state;
    pmem_state_e       state_next;

    logic              op_write;
    logic [IDX_W-1:0]  op_idx;
    logic [LINE_W-1:0] op_wdata;
    logic [CNT_W-1:0]  cnt;

    logic              req;
    logic [IDX_W-1:0]  req_idx;
    logic [CNT_W-1:0]  load_val;
    logic              addr_unused;

    logic              accept;
    logic              mem_we;
    logic              rdata_load;
    logic [IDX_W-1:0]  arr_raddr;
    logic [LINE_W-1:0] arr_rdata;

    assign req      = pmem_read | pmem_write;
    assign req_idx  = pmem_address[OFF_W +: IDX_W];
    // Write wins when both strobes are high
    assign load_val = pmem_write ? CNT_W'(WRITE_LATENCY - 1) : CNT_W'(READ_LATENCY - 1);

    // Offset bits and alias bits above the index play no part in addressing
    assign addr_unused = ^{pmem_address[ADDR_WIDTH-1:OFF_W+IDX_W], pmem_address[OFF_W-1:0]};

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req) begin
                    state_next = (load_val == '0) ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = RECOVER;
            RECOVER: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs and datapath controls
    always_comb begin
        accept     = 1'b0;
        mem_we     = 1'b0;
        rdata_load = 1'b0;
        pmem_resp  = 1'b0;
        arr_raddr  = op_idx;

        accept    = (state == IDLE) && req;
        pmem_resp = (state == RESP);
        mem_we    = (state == RESP) && op_write;
        // A latency-1 read enters RESP straight from IDLE, so look at the live request
        arr_raddr = accept ? req_idx : op_idx;
        rdata_load = (state_next == RESP) && (state != RESP) &&
                     !(accept ? pmem_write : op_write);
    end

    // Operation latches, latency counter, read-data register, error flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_write     <= 1'b0;
            op_idx       <= '0;
            op_wdata     <= '0;
            cnt          <= '0;
            pmem_rdata   <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (accept) begin
                op_write <= pmem_write;
                op_idx   <= req_idx;
                op_wdata <= pmem_wdata;
                cnt      <= load_val;
                if (pmem_read && pmem_write) begin
                    protocol_err <= 1'b1;
                end
            end else if ((state == BUSY) && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (rdata_load) begin
                pmem_rdata <= arr_rdata;
            end
        end
    end

    pmem_line_array #(
        .DEPTH_LINES (DEPTH_LINES),
        .LINE_W      (LINE_W)
    ) u_line_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (op_idx),
        .wdata (op_wdata),
        .raddr (arr_raddr),
        .rdata (arr_rdata)
    );

`ifdef PMEM_RESPONDER_STATS_EN
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    // Saturating completion counters, stepped in the RESP cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else if (state == RESP) begin
            if (op_write) begin
                if (wr_cnt != 32'hFFFF_FFFF) begin
                    wr_cnt <= wr_cnt + 32'd1;
                end
            end else begin
                if (rd_cnt != 32'hFFFF_FFFF) begin
                    rd_cnt <= rd_cnt + 32'd1;
                end
            end
        end
    end

    assign read_count  = rd_cnt;
    assign write_count = wr_cnt;
`else
    assign read_count  = '0;
    assign write_count = '0;
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// Self-checking bench for pmem_responder: a scoreboard queue of expected
// responses is filled as requests are driven and drained as pmem_resp fires.
module tb_pmem_responder;

    import pmem_types_pkg::*;

    localparam int unsigned RL = 10;
    localparam int unsigned WL = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    pmem_line_t  pmem_wdata;
    logic        pmem_resp;
    pmem_line_t  pmem_rdata;
    logic        protocol_err;
    logic [31:0] read_count;
    logic [31:0] write_count;

    typedef struct {
        bit         is_read;
        pmem_line_t data;
    } exp_t;

    exp_t       sb[$];
    pmem_line_t model [256];
    pmem_line_t exp_rdata;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;
    int         n_rd = 0;
    int         n_wr = 0;

    pmem_responder #(
        .ADDR_WIDTH    (32),
        .LINE_BYTES    (32),
        .DEPTH_LINES   (256),
        .READ_LATENCY  (RL),
        .WRITE_LATENCY (WL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata),
        .protocol_err (protocol_err),
        .read_count   (read_count),
        .write_count  (write_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int line_idx(input logic [31:0] a);
        return int'(a[12:5]);
    endfunction

    // Response monitor: every pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (!reset && pmem_resp) begin
            check_eq("resp_expected", 256'(sb.size() != 0), 256'(1));
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                if (e.is_read) begin
                    exp_rdata = e.data;
                    check_eq("read_data", pmem_rdata, e.data);
                end else begin
                    check_eq("rdata_held_on_write", pmem_rdata, exp_rdata);
                end
            end
        end
    end

    // One transaction: drive, wait for the pulse, check latency and width
    task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                       input pmem_line_t wd, input bit hold, input bit chk_lat);
        int   c;
        int   waited;
        bit   seen;
        exp_t e;
        @(negedge clk);
        pmem_read    = rd;
        pmem_write   = wr;
        pmem_address = addr;
        pmem_wdata   = wd;
        c = cyc;
        if (wr) begin
            model[line_idx(addr)] = wd;
            e.is_read = 1'b0;
            e.data    = '0;
            n_wr++;
        end else begin
            e.is_read = 1'b1;
            e.data    = model[line_idx(addr)];
            n_rd++;
        end
        sb.push_back(e);
        seen   = 1'b0;
        waited = 0;
        while (!seen && waited < 100) begin
            @(negedge clk);
            waited++;
            if (pmem_resp) seen = 1'b1;
        end
        check_eq("resp_seen", 256'(seen), 256'(1));
        if (chk_lat) begin
            check_eq("latency", 256'(cyc - (c + 1)), 256'(wr ? WL : RL));
        end
        if (!hold) begin
            pmem_read  = 1'b0;
            pmem_write = 1'b0;
        end
        @(negedge clk);
        check_eq("resp_width", 256'(pmem_resp), 256'(0));
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
    endtask

    initial begin
        pmem_line_t a5;
        pmem_line_t lx;
        pmem_line_t ly;
        pmem_line_t lz;
        pmem_line_t lp;
        int         r1;
        int         r2;
        int         waited;
        int         nresp;
        bit         seen;
        exp_t       e;

        a5 = {32{8'hA5}};
        lx = {8{32'h1234_5678}};
        ly = {8{32'hCAFE_F00D}};
        lz = {8{32'hDEAD_BEEF}};
        lp = {8{32'h0BAD_C0DE}};

        reset        = 1'b1;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        exp_rdata    = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_resp", 256'(pmem_resp), 256'(0));
        check_eq("rst_rdata", pmem_rdata, 256'(0));
        check_eq("rst_protocol_err", 256'(protocol_err), 256'(0));
        check_eq("rst_read_count", 256'(read_count), 256'(0));
        check_eq("rst_write_count", 256'(write_count), 256'(0));
        reset = 1'b0;
        @(negedge clk);

        // Latency and read-after-write
        txn(1'b0, 1'b1, 32'h0000_0040, a5, 1'b0, 1'b1);
        txn(1'b1, 1'b0, 32'h0000_0040, '0, 1'b0, 1'b1);

        // Request held one cycle past the response: served once only
        txn(1'b1, 1'b0, 32'h0000_0040, '0, 1'b1, 1'b1);
        repeat (RL + 4) @(negedge clk);
        check_eq("held_no_extra_resp", 256'(sb.size()), 256'(0));

        // Continuously held read: next response no earlier than L+2 after the first
        @(negedge clk);
        pmem_read    = 1'b1;
        pmem_address = 32'h0000_0040;
        e.is_read = 1'b1;
        e.data    = model[line_idx(32'h0000_0040)];
        sb.push_back(e);
        sb.push_back(e);
        n_rd += 2;
        r1 = 0;
        r2 = 0;
        nresp  = 0;
        waited = 0;
        while (nresp < 2 && waited < 100) begin
            @(negedge clk);
            waited++;
            if (pmem_resp) begin
                nresp++;
                if (nresp == 1) r1 = cyc; else r2 = cyc;
            end
        end
        pmem_read = 1'b0;
        check_eq("b2b_two_resps", 256'(nresp), 256'(2));
        check_eq("b2b_gap_min", 256'((r2 - r1) >= int'(RL + 2)), 256'(1));
        repeat (3) @(negedge clk);

        // Aliasing and offset bits
        txn(1'b0, 1'b1, 32'h0000_0000, lx, 1'b0, 1'b1);
        txn(1'b1, 1'b0, 32'h0000_2000, '0, 1'b0, 1'b1);
        txn(1'b1, 1'b0, 32'h0000_001F, '0, 1'b0, 1'b1);

        // Simultaneous read and write is a write plus a sticky error
        txn(1'b1, 1'b1, 32'h0000_0080, ly, 1'b0, 1'b1);
        check_eq("protocol_err_set", 256'(protocol_err), 256'(1));
        txn(1'b1, 1'b0, 32'h0000_0080, '0, 1'b0, 1'b1);
        check_eq("protocol_err_sticky", 256'(protocol_err), 256'(1));

        // Reset mid-write: no response and no commit
        txn(1'b0, 1'b1, 32'h0000_0100, lp, 1'b0, 1'b1);
        @(negedge clk);
        pmem_write   = 1'b1;
        pmem_address = 32'h0000_0100;
        pmem_wdata   = lz;
        repeat (4) @(negedge clk);
        reset      = 1'b1;
        pmem_write = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_mid_rdata", pmem_rdata, 256'(0));
        check_eq("rst_mid_protocol_err", 256'(protocol_err), 256'(0));
        reset     = 1'b0;
        exp_rdata = '0;
        n_rd = 0;
        n_wr = 0;
        nresp = 0;
        repeat (RL + 5) begin
            @(negedge clk);
            if (pmem_resp) nresp++;
        end
        check_eq("abort_no_resp", 256'(nresp), 256'(0));
        txn(1'b1, 1'b0, 32'h0000_0100, '0, 1'b0, 1'b1);

        // Stats: 3 reads and 2 writes since reset
        txn(1'b0, 1'b1, 32'h0000_0200, lx, 1'b0, 1'b1);
        txn(1'b1, 1'b0, 32'h0000_0200, '0, 1'b0, 1'b1);
        txn(1'b0, 1'b1, 32'h0000_0220, ly, 1'b0, 1'b1);
        txn(1'b1, 1'b0, 32'h0000_0220, '0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
`ifdef PMEM_RESPONDER_STATS_EN
        check_eq("read_count", 256'(read_count), 256'(n_rd));
        check_eq("write_count", 256'(write_count), 256'(n_wr));
`else
        check_eq("read_count", 256'(read_count), 256'(0));
        check_eq("write_count", 256'(write_count), 256'(0));
`endif
        check_eq("sb_drained", 256'(sb.size()), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
